// File: rtl/multi_input_gate_acc.sv
// Selectable WIDTH-input reduction gate with a registered result, plus an FSM that folds
// ACC_LEN valid results into one sticky value. Optional ones counter: define ONES_COUNT_EN.
module multi_input_gate_acc #(
    parameter int WIDTH   = 4,
    parameter int ACC_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_bus,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    input  logic             acc_start,
    output logic             o,
    output logic             o_valid,
    output logic             acc_o,
    output logic             acc_busy,
    output logic             acc_done
`ifdef ONES_COUNT_EN
    ,
    output logic [$clog2(ACC_LEN+1)-1:0] ones_cnt
`endif
);

    localparam int               CNT_W   = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic gate_f(input logic [2:0] m, input logic [WIDTH-1:0] b);
        logic r;
        r = 1'b0;
        case (m)
            3'd0:    r = &b;
            3'd1:    r = |b;
            3'd2:    r = ^b;
            3'd3:    r = ~(&b);
            3'd4:    r = ~(|b);
            3'd5:    r = ~(^b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic mode_ok(input logic [2:0] m);
        return (m <= 3'd5);
    endfunction

    // AND-family windows start from 1 so the first sample decides; others start from 0.
    function automatic logic init_val(input logic [2:0] m);
        return (m == 3'd0) || (m == 3'd3);
    endfunction

    function automatic logic fold_f(input logic [2:0] m, input logic acc, input logic g);
        logic r;
        r = acc;
        case (m)
            3'd0, 3'd3: r = acc & g;
            3'd1, 3'd4: r = acc | g;
            3'd2, 3'd5: r = acc ^ g;
            default:    r = acc;
        endcase
        return r;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_acc_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             w_start_ok;
    logic             w_fold;
    logic             w_g;
`ifdef ONES_COUNT_EN
    logic [CNT_W-1:0] r_ones_cnt;
    assign ones_cnt = r_ones_cnt;
`endif

    // Next-state decode; a valid acc_start in any state (re)opens a window.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = acc_start & mode_ok(mode);
        w_fold      = 1'b0;
        w_g         = gate_f(r_acc_mode, in_bus);
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_ACC;
                else            w_state_nxt = ST_IDLE;
            end
            ST_ACC: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_ACC;
                end else if (in_valid) begin
                    w_fold = 1'b1;
                    if (r_cnt == CNT_PRE) w_state_nxt = ST_DONE;
                    else                  w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_DONE: begin
                if (w_start_ok) w_state_nxt = ST_ACC;
                else            w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gate stage, FSM state and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o          <= 1'b0;
            o_valid    <= 1'b0;
            acc_o      <= 1'b0;
            acc_busy   <= 1'b0;
            acc_done   <= 1'b0;
            r_state    <= ST_IDLE;
            r_acc_mode <= 3'd0;
            r_cnt      <= '0;
`ifdef ONES_COUNT_EN
            r_ones_cnt <= '0;
`endif
        end else begin
            if (in_valid) begin
                o       <= gate_f(mode, in_bus);
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
            r_state  <= w_state_nxt;
            acc_busy <= (w_state_nxt == ST_ACC);
            acc_done <= (w_state_nxt == ST_DONE);
            if (w_start_ok) begin
                r_acc_mode <= mode;
                r_cnt      <= '0;
                acc_o      <= init_val(mode);
`ifdef ONES_COUNT_EN
                r_ones_cnt <= '0;
`endif
            end else if (w_fold) begin
                r_cnt      <= r_cnt + CNT_W'(1'b1);
                acc_o      <= fold_f(r_acc_mode, acc_o, w_g);
`ifdef ONES_COUNT_EN
                r_ones_cnt <= r_ones_cnt + CNT_W'(w_g);
`endif
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: doc/multi_input_gate_acc.md
Name: multi_input_gate_acc

Overview:
- Parametrised successor to the team's two-input gate blocks.
- Evaluates one selectable gate function (AND/OR/XOR/NAND/NOR/XNOR) over a WIDTH-bit input bus and registers the result with a valid strobe.
- An accumulation FSM folds ACC_LEN consecutive valid gate results into one sticky result, then pulses done.
- Used as a building block for lab exercises on registered logic and simple control.

Parameters:
- WIDTH, 4, number of gate inputs (>=2).
- ACC_LEN, 8, number of valid samples folded per accumulation window (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_bus  input  WIDTH  gate inputs; in_bus[0] corresponds to in0.
- mode  input  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_valid  input  1  in_bus/mode sample qualifier.
- acc_start  input  1  single-cycle pulse that starts an accumulation window.
- o  output  1  registered gate result.
- o_valid  output  1  high one cycle after an accepted sample.
- acc_o  output  1  accumulated result.
- acc_busy  output  1  high while a window is collecting samples.
- acc_done  output  1  one-cycle pulse when a window completes.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs become 0, the FSM enters IDLE and the sample counter clears. Reset mid-window aborts the window; no acc_done is issued.
- Gate stage, latency 1:
  - When in_valid=1: o <= f(mode, in_bus) and o_valid <= 1.
  - When in_valid=0: o_valid <= 0 and o holds its value.
  - Reserved modes: o <= 0, but o_valid still asserts.
- f is the reduction over all WIDTH bits:
  - AND = &in_bus; OR = |in_bus; XOR = ^in_bus.
  - NAND, NOR and XNOR are the inversions of AND, OR and XOR.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - On acc_start: latch mode into acc_mode_r, clear the counter, load acc_o with the init value (1 for AND/NAND, 0 otherwise), set acc_busy=1, go to ACC.
  - If acc_start arrives with a reserved mode, stay in IDLE and leave acc_o unchanged.
- ACC:
  - Each cycle with in_valid=1, compute g = f(acc_mode_r, in_bus) and update acc_o: acc_o & g for AND/NAND, acc_o | g for OR/NOR, acc_o ^ g for XOR/XNOR. Increment the counter.
  - Fold uses acc_mode_r; changes on mode during the window affect o only.
  - When the counter reaches ACC_LEN (on the cycle the ACC_LEN-th sample is taken), go to DONE.
  - acc_start in ACC restarts the window: reinitialise acc_o and the counter and latch the new mode. The concurrent sample is discarded from the window.
- DONE, one cycle:
  - acc_done=1, acc_busy=0, return to IDLE.
  - acc_o holds until the next acc_start.
  - acc_start during DONE is taken as in IDLE (next window begins next cycle, done pulse still occurs).
- acc_busy is 1 exactly in ACC.
- Counter width is clog2(ACC_LEN+1); it never wraps, because ACC exits at ACC_LEN.
- With ACC_LEN=1, the window closes on its first valid sample.

Optional Feature:
- Macro: ONES_COUNT_EN.
- Defined:
  - Adds output ones_cnt, width clog2(ACC_LEN+1).
  - Cleared at acc_start (and at reset) and incremented on each folded sample whose g=1.
  - Valid and held from DONE until the next acc_start.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan (WIDTH=4, ACC_LEN=4):
- Reset: hold rst_n=0 two cycles with random inputs -> o, o_valid, acc_o, acc_busy, acc_done all 0.
- Gate sweep:
  - mode 0..5 with in_bus=4'b1011 and in_valid=1 -> o = 0,1,1,1,0,0 respectively, each one cycle later with o_valid=1.
  - mode 6 -> o=0, o_valid=1.
- AND window:
  - acc_start with mode 0, then samples 4'hF,4'hF,4'h7,4'hF -> acc_done pulses the cycle after the 4th sample, acc_o=0, acc_busy high for 4 sample cycles.
  - If ONES_COUNT_EN is defined, ones_cnt=3.
- XOR window with gaps:
  - mode 2; samples 4'b0001, idle, 4'b0011, 4'b0111, idle, 4'b1111 -> acc_o = 1^0^1^0 = 0 and done after the 4th valid sample only.
- Restart and reset:
  - acc_start again after 2 samples -> counter restarts and done needs 4 further samples.
  - rst_n=0 mid-window -> no acc_done pulse and acc_o=0.
